// File: rtl/ddr2_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ddr2_ctrl_pkg : shared types/constants for the DDR-II B4 SRAM    |
// |                 controller (states, burst geometry, beat slice)  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package ddr2_ctrl_pkg;

    localparam int BURST_LEN  = 4;
    localparam int TURN_BEATS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_CMD   = 3'd2,
        ST_GAP   = 3'd3,
        ST_WDAT  = 3'd4,
        ST_RLAT  = 3'd5,
        ST_RDAT  = 3'd6,
        ST_RDONE = 3'd7
    } ctrl_state_t;

    // LSB position of beat 'beat' inside a packed burst of 'width'-bit beats
    function automatic int beat_lsb(input int beat, input int width);
        return beat * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_rd_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ddr2_rd_capture : read-latency counter, 4-beat read assembly and |
// |                   optional echo-clock check (DDR2_CTRL_CQ_CHECK_EN)|
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module ddr2_rd_capture
    import ddr2_ctrl_pkg::*;
#(
    parameter int DATA_BITS = 36,
    parameter int READ_LAT  = 3
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           rd_start,
    input  logic [DATA_BITS-1:0]           dq_in,
    input  logic                           cq,
    output logic                           lat_done,
    output logic                           cap_last,
    output logic                           rd_valid,
    output logic [BURST_LEN*DATA_BITS-1:0] rd_data,
    output logic                           cq_err
);

    localparam int CNT_W = $clog2(READ_LAT + BURST_LEN);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_pre   = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] c_first = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(READ_LAT + BURST_LEN - 1);

    // r_cnt counts beats since the read command beat; 0 means idle
    logic [CNT_W-1:0]                         r_cnt;
    logic [BURST_LEN-2:0][DATA_BITS-1:0]      r_buf;
    logic                                     w_window;
    logic [1:0]                               w_slot;

    assign w_window = (r_cnt >= c_first);
    assign w_slot   = 2'(r_cnt - c_first);
    assign lat_done = (r_cnt == c_pre);
    assign cap_last = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt    <= '0;
            r_buf    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_start) begin
                r_cnt <= c_one;
            end else if (r_cnt != '0) begin
                r_cnt <= cap_last ? '0 : r_cnt + c_one;
            end
            if (w_window && !cap_last) begin
                r_buf[w_slot] <= dq_in;
            end
            if (cap_last) begin
                rd_data  <= {dq_in, r_buf};
                rd_valid <= 1'b1;
            end
        end
    end

`ifdef DDR2_CTRL_CQ_CHECK_EN
    logic r_cq_prev;

    // CQ toggles once per beat; a repeated level inside the window is an error
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cq_prev <= 1'b0;
            cq_err    <= 1'b0;
        end else begin
            r_cq_prev <= cq;
            if (w_window && (cq == r_cq_prev)) begin
                cq_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_cq;
    assign w_unused_cq = cq;
    assign cq_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/ddr2_b4_sram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ddr2_b4_sram_ctrl : burst-of-4 common-I/O DDR-II SRAM initiator  |
// |   optional echo-clock check via DDR2_CTRL_CQ_CHECK_EN            |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module ddr2_b4_sram_ctrl
    import ddr2_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 18,
    parameter int DATA_BITS = 36,
    parameter int BWN       = 4,
    parameter int READ_LAT  = 3
) (
    input  logic                           clk,
    input  logic                           rst_b,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_rd,
    input  logic [ADDR_BITS-1:0]           req_addr,
    input  logic [BURST_LEN*DATA_BITS-1:0] req_wdata,
    input  logic [BURST_LEN*BWN-1:0]       req_bw_b,
    output logic                           rd_valid,
    output logic [BURST_LEN*DATA_BITS-1:0] rd_data,
    output logic                           k,
    output logic                           k_b,
    output logic                           c,
    output logic                           c_b,
    output logic [ADDR_BITS-1:0]           sa,
    output logic                           rw_b,
    output logic                           ld_b,
    output logic [BWN-1:0]                 bw_b,
    output logic [DATA_BITS-1:0]           dq_out,
    output logic                           dq_oe,
    input  logic [DATA_BITS-1:0]           dq_in,
    input  logic                           cq,
    output logic                           cq_err,
    output logic                           doff_b
);

    localparam logic [1:0] c_turn_last  = 2'(TURN_BEATS - 1);
    localparam logic [1:0] c_beat_last  = 2'(BURST_LEN - 1);
    localparam logic [1:0] c_beat_penul = 2'(BURST_LEN - 2);

    ctrl_state_t                    r_state;
    logic                           r_phase;
    logic [1:0]                     r_beat;
    logic                           r_rd;
    logic                           r_last_rd;
    logic [ADDR_BITS-1:0]           r_addr;
    logic [BURST_LEN*DATA_BITS-1:0] r_wdata;
    logic [BURST_LEN*BWN-1:0]       r_bw;
    logic [1:0]                     w_next_beat;
    logic                           w_accept;
    logic                           w_rd_start;
    logic                           w_lat_done;
    logic                           w_cap_last;

    assign w_next_beat = r_beat + 2'd1;
    assign w_accept    = req_valid && req_ready;
    assign w_rd_start  = (r_state == ST_CMD) && r_rd;

    // req_ready is only ever raised for a beat whose successor is a K-rise
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= ST_IDLE;
            r_phase   <= 1'b0;
            r_beat    <= '0;
            r_rd      <= 1'b0;
            r_last_rd <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bw      <= '0;
            k         <= 1'b1;
            k_b       <= 1'b0;
            c         <= 1'b1;
            c_b       <= 1'b0;
            sa        <= '0;
            rw_b      <= 1'b1;
            ld_b      <= 1'b1;
            bw_b      <= '1;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            req_ready <= 1'b0;
            doff_b    <= 1'b0;
        end else begin
            r_phase   <= ~r_phase;
            k         <= ~k;
            k_b       <= ~k_b;
            c         <= ~c;
            c_b       <= ~c_b;
            doff_b    <= 1'b1;
            ld_b      <= 1'b1;
            rw_b      <= 1'b1;
            bw_b      <= '1;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            req_ready <= 1'b0;
            if (w_accept) begin
                r_rd      <= req_rd;
                r_last_rd <= req_rd;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_bw      <= req_bw_b;
                if (!req_rd && r_last_rd) begin
                    r_state <= ST_TURN;
                    r_beat  <= '0;
                end else begin
                    r_state <= ST_CMD;
                    ld_b    <= 1'b0;
                    rw_b    <= req_rd;
                    sa      <= req_addr;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        req_ready <= ~r_phase;
                    end
                    ST_TURN: begin
                        if (r_beat == c_turn_last) begin
                            r_state <= ST_CMD;
                            ld_b    <= 1'b0;
                            rw_b    <= r_rd;
                            sa      <= r_addr;
                        end else begin
                            r_beat <= w_next_beat;
                        end
                    end
                    ST_CMD: begin
                        r_state <= r_rd ? ST_RLAT : ST_GAP;
                    end
                    ST_GAP: begin
                        r_state <= ST_WDAT;
                        r_beat  <= '0;
                        dq_oe   <= 1'b1;
                        dq_out  <= DATA_BITS'(r_wdata >> beat_lsb(0, DATA_BITS));
                        bw_b    <= BWN'(r_bw >> beat_lsb(0, BWN));
                    end
                    ST_WDAT: begin
                        if (r_beat == c_beat_last) begin
                            r_state   <= ST_IDLE;
                            req_ready <= ~r_phase;
                        end else begin
                            r_beat    <= w_next_beat;
                            dq_oe     <= 1'b1;
                            dq_out    <= DATA_BITS'(r_wdata >> beat_lsb(int'(w_next_beat), DATA_BITS));
                            bw_b      <= BWN'(r_bw >> beat_lsb(int'(w_next_beat), BWN));
                            req_ready <= (r_beat == c_beat_penul) && ~r_phase;
                        end
                    end
                    ST_RLAT: begin
                        if (w_lat_done) begin
                            r_state <= ST_RDAT;
                        end
                    end
                    ST_RDAT: begin
                        if (w_cap_last) begin
                            r_state   <= ST_RDONE;
                            req_ready <= ~r_phase;
                        end
                    end
                    ST_RDONE: begin
                        r_state   <= ST_IDLE;
                        req_ready <= ~r_phase;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    ddr2_rd_capture #(
        .DATA_BITS (DATA_BITS),
        .READ_LAT  (READ_LAT)
    ) u_rd_capture (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_start (w_rd_start),
        .dq_in    (dq_in),
        .cq       (cq),
        .lat_done (w_lat_done),
        .cap_last (w_cap_last),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .cq_err   (cq_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_ddr2_b4_sram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ddr2_b4_sram_ctrl : directed bench with a behavioural SRAM    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ddr2_b4_sram_ctrl;

    localparam int RL = 3;
`ifdef DDR2_CTRL_CQ_CHECK_EN
    localparam logic EXP_CQ_ERR = 1'b1;
`else
    localparam logic EXP_CQ_ERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_b = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_rd = 1'b0;
    logic [17:0]  req_addr = '0;
    logic [143:0] req_wdata = '0;
    logic [15:0]  req_bw_b = '1;
    logic         rd_valid;
    logic [143:0] rd_data;
    logic         k, k_b, c, c_b;
    logic [17:0]  sa;
    logic         rw_b, ld_b;
    logic [3:0]   bw_b;
    logic [35:0]  dq_out;
    logic         dq_oe;
    logic [35:0]  dq_in = '0;
    logic         cq = 1'b0;
    logic         cq_err;
    logic         doff_b;

    int checks = 0;
    int errors = 0;
    int beat   = 0;
    logic cq_stuck = 1'b0;

    ddr2_b4_sram_ctrl dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bw_b(req_bw_b),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .k(k), .k_b(k_b), .c(c), .c_b(c_b),
        .sa(sa), .rw_b(rw_b), .ld_b(ld_b), .bw_b(bw_b),
        .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
        .cq(cq), .cq_err(cq_err), .doff_b(doff_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) beat <= beat + 1;

    // Behavioural SRAM: latches commands, merges write beats, returns read beats
    logic [143:0] mem [logic [17:0]];
    logic         m_active = 1'b0;
    logic         m_rd = 1'b0;
    logic [17:0]  m_addr = '0;
    int           m_cmd = 0;
    int           m_off;
    logic [143:0] m_burst;
    logic [35:0]  m_word;

    always @(negedge clk) begin
        if (!rst_b) begin
            m_active = 1'b0;
        end else begin
            if (!ld_b) begin
                m_active = 1'b1;
                m_cmd    = beat;
                m_rd     = rw_b;
                m_addr   = sa;
            end
            m_off = beat - m_cmd;
            if (m_active && !m_rd && dq_oe && m_off >= 2 && m_off <= 5) begin
                m_burst = mem.exists(m_addr) ? mem[m_addr] : '0;
                m_word  = m_burst[(m_off-2)*36 +: 36];
                for (int j = 0; j < 4; j++)
                    if (!bw_b[j]) m_word[j*9 +: 9] = dq_out[j*9 +: 9];
                m_burst[(m_off-2)*36 +: 36] = m_word;
                mem[m_addr] = m_burst;
            end
            dq_in = '0;
            if (m_active && m_rd && m_off >= RL && m_off <= RL+3 && mem.exists(m_addr)) begin
                m_burst = mem[m_addr];
                dq_in   = m_burst[(m_off-RL)*36 +: 36];
            end
            cq = cq_stuck ? 1'b1 : k;
        end
    end

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for the handshake, return the beat ld_b goes low
    task automatic issue(input logic rd, input logic [17:0] addr, input logic [143:0] wd,
                         input logic [15:0] bw, output int cmd);
        req_rd = rd; req_addr = addr; req_wdata = wd; req_bw_b = bw; req_valid = 1'b1;
        cmd = -1;
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
        if (req_ready) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            for (int i = 0; i < 8 && ld_b; i++) @(negedge clk);
            if (!ld_b) cmd = beat;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rd(output int b, output logic oe_seen);
        b = -1;
        oe_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dq_oe) oe_seen = 1'b1;
            if (rd_valid) begin
                b = beat;
                break;
            end
        end
    endtask

    logic [143:0] w1, w2, w3, ones, w3_exp;
    int t1, t2, t3, tr1, tr2, tr3, tw, rv1, rv2, rv3;
    logic oe_seen;

    initial begin
        w1     = 144'h444444444_333333333_222222222_111111111;
        w2     = 144'h0AAAAAAAA_055555555_0F0F0F0F0_123456789;
        ones   = {4{36'hFFFFFFFFF}};
        w3     = '0;
        w3_exp = 144'h007FFFFFF_FF803FFFF_FFFFC01FF_FFFFFFE00;

        #1 rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clk",   144'({k, k_b, c, c_b}), 144'(4'b1010));
        check("rst_cmd",   144'({sa, rw_b, ld_b, bw_b}), 144'({18'h0, 1'b1, 1'b1, 4'hF}));
        check("rst_dq",    144'({dq_out, dq_oe}), 144'(0));
        check("rst_misc",  144'({req_ready, rd_valid, cq_err, doff_b}), 144'(0));
        check("rst_rdata", rd_data, 144'(0));

        rst_b = 1'b1;
        @(negedge clk);
        check("post_rst", 144'({doff_b, req_ready, k}), 144'(3'b110));

        // write 0x11111
        issue(1'b0, 18'h11111, w1, 16'h0000, t1);
        check("wr_cmd", 144'({ld_b, rw_b, sa, k}), 144'({1'b0, 1'b0, 18'h11111, 1'b1}));
        for (int off = 1; off <= 5; off++) begin
            @(negedge clk);
            check("wr_oe", 144'(dq_oe), 144'(off >= 2));
            if (off == 1) check("wr_gap", 144'({ld_b, rw_b, sa}), 144'({1'b1, 1'b1, 18'h11111}));
            else check("wr_data", 144'({dq_out, bw_b}), 144'({w1[(off-2)*36 +: 36], 4'h0}));
        end
        check("wr_ready_b2b", 144'(req_ready), 144'(1));

        // back-to-back writes to 0x33333: all ones, then zeros under per-beat byte masks
        issue(1'b0, 18'h33333, ones, 16'h0000, t2);
        check("wr_spacing", 144'(t2 - t1), 144'(6));
        repeat (5) @(negedge clk);
        issue(1'b0, 18'h33333, w3, 16'h7BDE, t3);
        check("wr_spacing2", 144'(t3 - t2), 144'(6));
        repeat (2) @(negedge clk);
        check("wr_bw_b0", 144'(bw_b), 144'(4'hE));
        repeat (3) @(negedge clk);

        // read 0x11111 directly after a write: no turnaround
        issue(1'b1, 18'h11111, '0, 16'hFFFF, tr1);
        check("rd_after_wr", 144'(tr1 - t3), 144'(6));
        check("rd_cmd", 144'({ld_b, rw_b, sa}), 144'({1'b0, 1'b1, 18'h11111}));
        wait_rd(rv1, oe_seen);
        check("rd_latency", 144'(rv1 - tr1), 144'(RL + 4));
        check("rd_data1", rd_data, w1);
        check("rd_ready", 144'(req_ready), 144'(1));

        // back-to-back read of the masked burst
        issue(1'b1, 18'h33333, '0, 16'hFFFF, tr2);
        check("rd_spacing", 144'(tr2 - tr1), 144'(8));
        wait_rd(rv2, oe_seen);
        check("rd_latency2", 144'(rv2 - tr2), 144'(RL + 4));
        check("rd_data_bw", rd_data, w3_exp);
        check("rd_no_oe", 144'(oe_seen), 144'(0));
        check("cq_err_ok", 144'(cq_err), 144'(0));

        // write straight after read: two turnaround beats
        issue(1'b0, 18'h22222, w2, 16'h0000, tw);
        check("turn_delay", 144'(tw - rv2), 144'(3));
        check("turn_k", 144'(k), 144'(1));
        @(negedge clk);
        check("rv_pulse", 144'(rd_valid), 144'(0));
        repeat (3) @(negedge clk);
        check("wr2_beat2", 144'({dq_oe, dq_out}), 144'({1'b1, w2[2*36 +: 36]}));

        // reset in the middle of the data phase
        #1 rst_b = 1'b0;
        #1;
        check("rst_mid", 144'({dq_oe, ld_b, doff_b, req_ready}), 144'(4'b0100));
        repeat (2) @(negedge clk);
        check("rst_hold_rv", 144'(rd_valid), 144'(0));
        rst_b = 1'b1;
        @(negedge clk);
        check("rst_resume", 144'({doff_b, req_ready, k}), 144'(3'b110));

        // read with the echo clock stuck high
        cq_stuck = 1'b1;
        issue(1'b1, 18'h11111, '0, 16'hFFFF, tr3);
        check("rd_after_rst", 144'({ld_b, rw_b}), 144'(2'b01));
        wait_rd(rv3, oe_seen);
        check("rd_latency3", 144'(rv3 - tr3), 144'(RL + 4));
        check("rd_data3", rd_data, w1);
        check("cq_err_set", 144'(cq_err), 144'(EXP_CQ_ERR));
        repeat (4) @(negedge clk);
        check("cq_err_sticky", 144'(cq_err), 144'(EXP_CQ_ERR));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired at beat %0d", beat);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ddr2_b4_sram_ctrl.md
# ddr2_b4_sram_ctrl

- Initiator-side controller for the 36-bit burst-of-4 common-I/O DDR-II SRAM (k7i323684m class).
- Accepts whole-burst read/write requests on a ready/valid user port and generates K/K_b, C/C_b, SA, RW_b, LD_b, BW_b and the DQ bus with turnaround.
- Returns assembled 4-beat read bursts to the user.
- Sits between the system fabric and the SRAM pad ring.

## Interface
- ADDR_BITS, 18, burst address width
- DATA_BITS, 36, DQ width
- BWN, 4, byte-write lanes
- READ_LAT, 3, beats from command beat to first read-data capture beat (min 2)
- clk  in  1  beat clock: one rising edge per DDR beat (2x K frequency)
- rst_b  in  1  asynchronous, active-low reset
- req_valid / req_ready  in/out  1  request handshake; transfer when both high on a clk edge
- req_rd  in  1  1=read, 0=write
- req_addr  in  ADDR_BITS  burst address
- req_wdata  in  4*DATA_BITS  beat n at [n*DATA_BITS +: DATA_BITS]
- req_bw_b  in  4*BWN  active-low byte writes per beat, same packing
- rd_valid  out  1  one-cycle pulse, burst complete
- rd_data  out  4*DATA_BITS  read burst, beat 0 lowest
- k, k_b, c, c_b  out  1  SRAM clocks; c/c_b follow k/k_b
- sa  out  ADDR_BITS;  rw_b, ld_b  out  1;  bw_b  out  BWN
- dq_out  out  DATA_BITS;  dq_oe  out  1;  dq_in  in  DATA_BITS  split tristate, pad ring merges
- cq  in  1  echo clock;  cq_err  out  1  sticky echo-clock error
- doff_b  out  1  DLL enable

## Operation
- Reset values: k=1, k_b=0, c=1, c_b=0, sa=0, rw_b=1, ld_b=1, bw_b=all 1, dq_out=0, dq_oe=0, req_ready=0, rd_valid=0, rd_data=0, cq_err=0, doff_b=0.
- First clk after reset: doff_b goes to 1.
- phase toggles every clk. k<=~k; k_b<=~k_b. A K-rise beat is one where phase=0.
- States:
  - IDLE: req_ready=1 only on the beat preceding a K-rise. Acceptance moves to CMD.
  - CMD (1 beat): ld_b=0, rw_b=req_rd, sa=req_addr; req_wdata and req_bw_b are latched.
  - Write path: GAP (1 beat, command outputs return to ld_b=1, rw_b=1, sa held) → WDAT (4 beats, dq_oe=1, beat n drives dq_out/bw_b) → IDLE.
  - Read path: RLAT (READ_LAT-1 beats) → RDAT (4 beats, capture dq_in into beat slot) → RDONE (rd_valid pulse) → IDLE.
- Turnaround: a write accepted after a read incurs 2 extra idle beats before CMD (TURN state). A read after a write needs none.
- Back-to-back bursts of the same direction are issued with no idle K cycle beyond state occupancy.
- Reset asserted mid-burst: all outputs return to reset values immediately; the partial burst is discarded and no rd_valid is issued.

## Timing
- Write: command at beat t (K-rise); data beats at t+2..t+5; next command earliest at t+6.
- Read: command at t; capture at t+READ_LAT..t+READ_LAT+3; rd_valid at t+READ_LAT+4; next read at the first K-rise ≥ t+READ_LAT+4. A next write adds +2 beats.
- Outputs are registered. k/k_b are phase-shifted 90° by the pad ring to centre the edges on data.

## Configuration
- DDR2_CTRL_CQ_CHECK_EN defined: during RDAT, cq is sampled every beat. It must differ from the previous beat; otherwise cq_err sets and stays set until reset.
- Macro undefined: cq is ignored and cq_err is tied 0.

## Structure
- Package ddr2_ctrl_pkg holds:
  - state enum
  - BURST_LEN=4
  - TURN_BEATS=2
  - beat-slice helper function
- One sub-module ddr2_rd_capture holds the READ_LAT beat counter, rd_data assembly and the optional CQ check.

## Test plan
- Write addr 0x11111, data beats 0x111111111/0x222222222/0x333333333/0x444444444, bw all 0 → ld_b=0 at t. dq_oe high t+2..t+5 with the four words in order.
- Read addr 0x11111 with the SRAM model attached → rd_valid at t+7. rd_data holds the four words, beat 0 lowest.
- Write 0x33333 with per-beat bw_b 0xE, 0xD, 0xB, 0x7 then read back → only the selected byte of each beat is zeroed.
- Read then immediately request write → write CMD delayed 2 extra beats. dq_oe never overlaps the capture window.
- Reset asserted during WDAT beat 2 → dq_oe=0 and ld_b=1 at once. After release, doff_b=1 and req_ready resumes on a pre-K-rise beat.
- With DDR2_CTRL_CQ_CHECK_EN, cq held at 1 through a read → cq_err=1 and sticky. Without the macro, cq_err stays 0.
